// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider: run-time divisor
// staging, phase restart and the divided outputs.
interface clk_div_prog_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             restart;
  logic             div_load;
  logic [CNT_W-1:0] div_half;
  logic             clk_out;
  logic             tick;
  logic             pending;
  logic [CNT_W-1:0] active_half;

  modport master (
    output en, restart, div_load, div_half,
    input  clk_out, tick, pending, active_half
  );

  modport slave (
    input  en, restart, div_load, div_half,
    output clk_out, tick, pending, active_half
  );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable 50%-duty clock divider with a staged, glitch-free divisor update
// that lands only on a half-period boundary, plus synchronous phase restart.
module clk_div_prog #(
  parameter int          CNT_W        = 16,
  parameter int unsigned DEFAULT_HALF = 2351
) (
  input  logic           clk_in,
  input  logic           reset,
  clk_div_prog_if.slave  bus
);
  localparam logic [CNT_W-1:0] RESET_HALF = CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] active_half;
  logic             clk_q;
  logic             tick_q;
  logic             pending_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      counter     <= '0;
      shadow      <= RESET_HALF;
      active_half <= RESET_HALF;
      clk_q       <= 1'b0;
      tick_q      <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;

      if (bus.restart) begin
        counter <= '0;
        clk_q   <= 1'b0;
        if (pending_q) begin
          active_half <= shadow;
          pending_q   <= 1'b0;
        end
      end else if (bus.en) begin
        if (counter == active_half) begin
          // The counter is zero whenever the divisor changes, so a shrinking
          // divisor can never leave the counter above the new terminal count.
          counter <= '0;
          clk_q   <= ~clk_q;
          tick_q  <= ~clk_q;
          if (pending_q) begin
            active_half <= shadow;
            pending_q   <= 1'b0;
          end
        end else begin
          counter <= counter + CNT_W'(1);
        end
      end

      // NOTE: non-blocking assignments read the pre-edge shadow/pending above,
      // and this later assignment wins, so a coincident load re-arms pending.
      if (bus.div_load) begin
        shadow    <= bus.div_half;
        pending_q <= 1'b1;
      end
    end
  end

  assign bus.clk_out     = clk_q;
  assign bus.tick        = tick_q;
  assign bus.pending     = pending_q;
  assign bus.active_half = active_half;
endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Programmable, parametrised successor to the fixed-ratio 50%-duty clock dividers in the VFD timing chain.
- Generates a square-wave enable clock plus a single-cycle tick from the system clock.
- Half-period is software/controller selectable at run time. Updates are glitch-free and land only on a half-period boundary.
- Optional synchronous restart aligns the phase to an external event, such as PWM carrier start or a frequency-command change.

Parameters:
- CNT_W, 16: counter and divisor width in bits.
- DEFAULT_HALF, 2351: half-period terminal count loaded at reset. Half-period = DEFAULT_HALF+1 input cycles.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable. When low, the counter and outputs freeze.
- restart  input  1  synchronous phase restart; applies the pending divisor immediately.
- div_half  input  CNT_W  new half-period terminal count; sampled only when div_load=1.
- div_load  input  1  single-cycle request to stage div_half.
- clk_out  output  1  divided square wave, 50% duty.
- tick  output  1  one-cycle pulse in the cycle clk_out becomes 1.
- pending  output  1  a staged divisor is waiting to be applied.
- active_half  output  CNT_W  terminal count currently in use.

Behaviour:
- Internal state:
  - counter[CNT_W-1:0]
  - shadow[CNT_W-1:0]
  - active_half
  - clk_out
  - pending
  - tick
- All outputs are registered.
- Priority per cycle: reset > restart > en. div_load is evaluated independently of en.
- Reset: on clk_in edge with reset=1, the following values apply; all other inputs are ignored.
  - counter=0
  - clk_out=0
  - tick=0
  - pending=0
  - active_half=DEFAULT_HALF
  - shadow=DEFAULT_HALF
  - Reset asserted mid-period aborts the period; there is no partial toggle.
- Toggle event: en=1, restart=0, counter==active_half. Then:
  - counter<=0
  - clk_out<=~clk_out
  - if pending=1: active_half<=shadow and pending<=0
- Full period = 2*(active_half+1) cycles. active_half=0 gives clk_out toggling every enabled cycle (clk_in/2).
- Normal count: en=1, restart=0, counter!=active_half gives counter<=counter+1 with clk_out unchanged.
- Because the counter is always 0 when active_half changes, there is no overshoot or wrap when the divisor shrinks.
- tick: 1 for exactly the one cycle following a toggle event that drives clk_out 0->1; otherwise 0.
  - tick=0 during reset, restart and en=0 cycles.
- en=0: counter, clk_out, active_half hold; tick=0. div_load is still honoured: it updates shadow and sets pending.
- div_load=1:
  - shadow<=div_half, pending<=1.
  - A second load before application overwrites shadow; the last value wins.
- div_load coincident with a toggle event:
  - The toggle applies the OLD shadow only if pending was already 1 before the cycle.
  - The new div_half goes to shadow with pending=1 and is applied at the next toggle. There is no same-cycle bypass.
- restart=1 (with reset=0):
  - counter<=0, clk_out<=0, tick<=0.
  - If pending=1: active_half<=shadow, pending<=0.
  - Restart ignores en.
  - With a simultaneous div_load, active_half takes the previous shadow, while shadow takes div_half and pending stays 1.
- Counter arithmetic is unsigned CNT_W bits. counter never exceeds active_half, so no wrap-around occurs.

Test Plan:
- Reset, en=1, default parameters:
  - first clk_out rise occurs 2352 cycles after reset release;
  - period is 4704 cycles at 50% duty;
  - tick is high for 1 cycle per period, aligned with each clk_out rise.
- div_half=9 loaded mid high-phase while active_half=2351:
  - pending=1 until the current half-period ends;
  - active_half then becomes 9 and pending clears;
  - subsequent half-periods are 10 cycles, with no short or long glitch half-period.
- div_load with div_half=3 and div_half=5 on consecutive cycles, then a toggle:
  - active_half=5 after the boundary, and half-periods are 6 cycles.
- en deasserted for 20 cycles mid-count:
  - counter and clk_out frozen, tick=0 throughout;
  - resuming completes the half-period with exactly the remaining count;
  - a div_load issued during en=0 still sets pending.
- restart pulse with pending=1 and shadow=0:
  - next cycle clk_out=0, counter=0, active_half=0;
  - clk_out then toggles every cycle, with tick every 2nd cycle.
- reset asserted mid-period with pending=1 and shadow=7:
  - all state returns to reset values, active_half=2351, pending=0;
  - the staged value 7 is discarded.
